// File: rtl/riscv_uc_pkg.sv
// Shared encodings for the multicycle control unit and the riscv datapath.
// Opcodes, controller states, ALU operation codes and mux-select values.
package riscv_uc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EX_R   = 4'd3,
        ST_EX_I   = 4'd4,
        ST_WB_ALU = 4'd5,
        ST_ADDR   = 4'd6,
        ST_MEM_RD = 4'd7,
        ST_WB_MEM = 4'd8,
        ST_MEM_WR = 4'd9,
        ST_BR     = 4'd10,
        ST_JMP    = 4'd11,
        ST_TRAP   = 4'd12
    } uc_state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // select_mux_1: PC source
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_ALU = 2'b10;

    // select_mux_2 / select_mux_3: ALU operands
    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;
    localparam logic [1:0] A_RS1  = 2'b00;
    localparam logic [1:0] A_PC   = 2'b01;

    // select_mux_4: writeback source
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    function automatic logic is_wait_state(uc_state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/riscv_uc_wait_cnt.sv
// Consecutive not-ready cycle counter for the memory handshake.
// expired flags the cycle that would make the count reach WAIT_TIMEOUT.
module riscv_uc_wait_cnt #(
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    // Saturate so a disabled timeout never wraps back into a stale compare.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (WAIT_TIMEOUT > 0) begin : g_timeout
            assign expired = inc && (cnt_q == W'(WAIT_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/riscv_uc_mc.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback
// for riscv_dp with a variable-latency memory handshake and trap on error.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RST       | pc_reset held for RESET_HOLD cycles after reset falls
// FETCH     | instruction read; IR/PC load when mem_ready
// DECODE    | dispatch on opcode
// EX_R/EX_I | register / immediate ALU operation
// WB_ALU    | write ALU result
// ADDR      | compute load/store address
// MEM_RD    | data read, wait for mem_ready
// WB_MEM    | write loaded data
// MEM_WR    | data write, wait for mem_ready
// BR        | compare; PC <= old_pc+imm when branch
// JMP       | JAL/JALR: rd <= pc+4 and redirect PC
// TRAP      | terminal; only reset leaves
module riscv_uc_mc
    import riscv_uc_pkg::*;
#(
    parameter int RESET_HOLD   = 2,
    parameter int WAIT_TIMEOUT = 15,
    parameter int SUPPORT_JAL  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch,
    input  logic       mem_ready,
    output logic       pc_load,
    output logic       pc_reset,
    output logic       ir_load,
    output logic       mem_re,
    output logic       mem_we,
    output logic       reg_file_write,
    output logic [1:0] alu_op,
    output logic [1:0] select_mux_1,
    output logic [1:0] select_mux_2,
    output logic [1:0] select_mux_3,
    output logic [1:0] select_mux_4,
    output logic       trap,
    output logic [3:0] state_dbg
);

    localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    uc_state_e     state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          wait_expired;

    riscv_uc_wait_cnt #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_wait_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_d != state_q),
        .inc     (is_wait_state(state_q) && !mem_ready),
        .expired (wait_expired)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_RST: begin
                if (hold_q == HW'(RESET_HOLD - 1)) state_d = ST_FETCH;
                else                               hold_d  = hold_q + HW'(1);
            end
            ST_FETCH: begin
                if (mem_ready)         state_d = ST_DECODE;
                else if (wait_expired) state_d = ST_TRAP;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_R:              state_d = ST_EX_R;
                    OP_I:              state_d = ST_EX_I;
                    OP_LOAD, OP_STORE: state_d = ST_ADDR;
                    OP_BRANCH:         state_d = ST_BR;
                    OP_JAL, OP_JALR:   state_d = (SUPPORT_JAL != 0) ? ST_JMP : ST_TRAP;
                    default:           state_d = ST_TRAP;
                endcase
            end
            ST_EX_R, ST_EX_I: state_d = ST_WB_ALU;
            ST_ADDR:          state_d = (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready)         state_d = ST_WB_MEM;
                else if (wait_expired) state_d = ST_TRAP;
            end
            ST_MEM_WR: begin
                if (mem_ready)         state_d = ST_FETCH;
                else if (wait_expired) state_d = ST_TRAP;
            end
            ST_WB_ALU, ST_WB_MEM, ST_BR, ST_JMP: state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // IR still holds the instruction, so WB_ALU re-derives the EX operand select.
    always_comb begin
        pc_load        = 1'b0;
        pc_reset       = 1'b0;
        ir_load        = 1'b0;
        mem_re         = 1'b0;
        mem_we         = 1'b0;
        reg_file_write = 1'b0;
        alu_op         = ALU_ADD;
        select_mux_1   = PC_SEQ;
        select_mux_2   = B_RS2;
        select_mux_3   = A_RS1;
        select_mux_4   = WB_SEL_ALU;
        trap           = 1'b0;
        case (state_q)
            ST_RST: pc_reset = 1'b1;
            ST_FETCH: begin
                mem_re  = 1'b1;
                ir_load = mem_ready;
                pc_load = mem_ready;
            end
            ST_EX_R: alu_op = ALU_FUNCT;
            ST_EX_I: begin
                alu_op       = ALU_FUNCT;
                select_mux_2 = B_IMM;
            end
            ST_WB_ALU: begin
                reg_file_write = 1'b1;
                alu_op         = ALU_FUNCT;
                select_mux_2   = (opcode == OP_I) ? B_IMM : B_RS2;
            end
            ST_ADDR: select_mux_2 = B_IMM;
            ST_MEM_RD: begin
                mem_re       = 1'b1;
                select_mux_2 = B_IMM;
            end
            ST_WB_MEM: begin
                reg_file_write = 1'b1;
                select_mux_4   = WB_SEL_MEM;
            end
            ST_MEM_WR: begin
                mem_we       = 1'b1;
                select_mux_2 = B_IMM;
            end
            ST_BR: begin
                alu_op = ALU_SUB;
                if (branch) begin
                    pc_load      = 1'b1;
                    select_mux_1 = PC_REL;
                end
            end
            ST_JMP: begin
                reg_file_write = 1'b1;
                select_mux_4   = WB_SEL_PC4;
                pc_load        = 1'b1;
                if (opcode == OP_JALR) begin
                    select_mux_1 = PC_ALU;
                    select_mux_2 = B_IMM;
                end else begin
                    select_mux_1 = PC_REL;
                end
            end
            ST_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_riscv_uc_mc.sv
// Directed bench for riscv_uc_mc: instance a has JAL support and a 4-cycle
// handshake timeout, instance b shares its stimulus but has JAL disabled.
module tb_riscv_uc_mc;
    import riscv_uc_pkg::*;

    logic       clk = 1'b0;
    logic       reset, branch, mem_ready;
    logic [6:0] opcode;

    logic       a_pc_load, a_pc_reset, a_ir_load, a_mem_re, a_mem_we, a_reg_file_write, a_trap;
    logic [1:0] a_alu_op, a_sel1, a_sel2, a_sel3, a_sel4;
    logic [3:0] a_state;
    logic       b_pc_load, b_pc_reset, b_ir_load, b_mem_re, b_mem_we, b_reg_file_write, b_trap;
    logic [1:0] b_alu_op, b_sel1, b_sel2, b_sel3, b_sel4;
    logic [3:0] b_state;

    int n_cmp = 0;
    int n_bad = 0;

    riscv_uc_mc #(.RESET_HOLD(2), .WAIT_TIMEOUT(4), .SUPPORT_JAL(1)) u_a (
        .clk(clk), .reset(reset), .opcode(opcode), .branch(branch), .mem_ready(mem_ready),
        .pc_load(a_pc_load), .pc_reset(a_pc_reset), .ir_load(a_ir_load), .mem_re(a_mem_re),
        .mem_we(a_mem_we), .reg_file_write(a_reg_file_write), .alu_op(a_alu_op),
        .select_mux_1(a_sel1), .select_mux_2(a_sel2), .select_mux_3(a_sel3),
        .select_mux_4(a_sel4), .trap(a_trap), .state_dbg(a_state)
    );

    riscv_uc_mc #(.RESET_HOLD(2), .WAIT_TIMEOUT(4), .SUPPORT_JAL(0)) u_b (
        .clk(clk), .reset(reset), .opcode(opcode), .branch(branch), .mem_ready(mem_ready),
        .pc_load(b_pc_load), .pc_reset(b_pc_reset), .ir_load(b_ir_load), .mem_re(b_mem_re),
        .mem_we(b_mem_we), .reg_file_write(b_reg_file_write), .alu_op(b_alu_op),
        .select_mux_1(b_sel1), .select_mux_2(b_sel2), .select_mux_3(b_sel3),
        .select_mux_4(b_sel4), .trap(b_trap), .state_dbg(b_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first FETCH cycle after the 2-cycle reset hold.
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step(); step();
    endtask

    function automatic int a_en();
        return {a_pc_load, a_ir_load, a_mem_re, a_mem_we, a_reg_file_write};
    endfunction

    function automatic int b_en();
        return {b_pc_load, b_ir_load, b_mem_re, b_mem_we, b_reg_file_write};
    endfunction

    initial begin
        reset = 1'b1; branch = 1'b0; mem_ready = 1'b0; opcode = 7'h00;
        step(); step(); step();
        check("rst_state", a_state, ST_RST);
        check("rst_pc_reset", a_pc_reset, 1);
        check("rst_enables", a_en(), 0);
        check("rst_trap", a_trap, 0);
        check("rst_selects", {a_alu_op, a_sel1, a_sel2, a_sel3, a_sel4}, 0);

        reset = 1'b0; #1;
        check("hold1_pc_reset", a_pc_reset, 1);
        check("hold1_mem_re", a_mem_re, 0);
        step();
        check("hold2_pc_reset", a_pc_reset, 1);
        check("hold2_state", a_state, ST_RST);
        step();
        check("fetch_state", a_state, ST_FETCH);
        check("fetch_mem_re", a_mem_re, 1);
        check("fetch_pc_reset", a_pc_reset, 0);
        check("fetch_wait_ir_load", a_ir_load, 0);

        // R-type with memory always ready
        opcode = OP_R; mem_ready = 1'b1; #1;
        check("r_fetch_loads", {a_ir_load, a_pc_load, a_sel1}, {1'b1, 1'b1, 2'b00});
        step();
        check("r_decode_state", a_state, ST_DECODE);
        check("r_decode_en", a_en(), 0);
        step();
        check("r_ex_state", a_state, ST_EX_R);
        check("r_ex_alu", {a_alu_op, a_sel2, a_sel3}, 6'b10_00_00);
        check("r_ex_rfw", a_reg_file_write, 0);
        step();
        check("r_wb_state", a_state, ST_WB_ALU);
        check("r_wb_rfw_sel4", {a_reg_file_write, a_sel4}, 3'b1_00);
        opcode = OP_LOAD;
        step();
        check("r_back_fetch", a_state, ST_FETCH);

        // load with three not-ready cycles in MEM_RD
        step();
        step();
        check("ld_addr", {a_state, a_alu_op, a_sel2, a_sel3}, {ST_ADDR, 6'b00_01_00});
        step(); mem_ready = 1'b0; #1;
        check("ld_wait1", {a_state, a_mem_re}, {ST_MEM_RD, 1'b1});
        step();
        check("ld_wait2_mem_re", a_mem_re, 1);
        step();
        check("ld_wait3_mem_re", a_mem_re, 1);
        step(); mem_ready = 1'b1; #1;
        check("ld_ready_cycle", {a_state, a_mem_re, a_trap}, {ST_MEM_RD, 1'b1, 1'b0});
        opcode = OP_STORE;
        step();
        check("ld_wb", {a_state, a_reg_file_write, a_sel4, a_mem_re}, {ST_WB_MEM, 1'b1, 2'b01, 1'b0});
        step();
        check("ld_back_fetch", a_state, ST_FETCH);

        // store with two not-ready cycles in MEM_WR
        step(); step(); step(); mem_ready = 1'b0; #1;
        check("st_wait1", {a_state, a_mem_we, a_reg_file_write}, {ST_MEM_WR, 1'b1, 1'b0});
        step();
        check("st_wait2", {a_mem_we, a_reg_file_write}, 2'b10);
        step(); mem_ready = 1'b1; #1;
        check("st_ready", {a_mem_we, a_reg_file_write}, 2'b10);
        opcode = OP_BRANCH;
        step();
        check("st_back_fetch", {a_state, a_mem_we}, {ST_FETCH, 1'b0});

        // branch taken then not taken
        step(); step(); branch = 1'b1; #1;
        check("br_taken", {a_state, a_pc_load, a_sel1, a_alu_op}, {ST_BR, 1'b1, 2'b01, 2'b01});
        step(); branch = 1'b0;
        check("br_taken_next", a_state, ST_FETCH);
        step(); step();
        check("br_not_taken", {a_state, a_pc_load, a_sel1}, {ST_BR, 1'b0, 2'b00});
        opcode = OP_JAL;
        step();
        check("br_nt_next", a_state, ST_FETCH);

        // JAL on both instances: a jumps, b traps
        step(); step();
        check("jal_a", {a_state, a_pc_load, a_sel1, a_reg_file_write, a_sel4},
              {ST_JMP, 1'b1, 2'b01, 1'b1, 2'b10});
        check("jal_b_trap", {b_state, b_trap}, {ST_TRAP, 1'b1});
        opcode = OP_JALR;
        step();
        check("jal_next", a_state, ST_FETCH);
        step(); step();
        check("jalr_a", {a_state, a_pc_load, a_sel1, a_alu_op, a_sel2, a_sel3, a_sel4},
              {ST_JMP, 1'b1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10});
        check("jalr_b_sticky", {b_trap, 5'(b_en())}, {1'b1, 5'd0});
        opcode = 7'b1111111;
        step(); step(); step();

        // illegal opcode: terminal trap
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0]; #1;
            check("illegal_trap", {a_state, a_trap, 5'(a_en())}, {ST_TRAP, 1'b1, 5'd0});
            step();
        end

        // handshake timeout in FETCH
        do_reset();
        check("to_w1", {a_state, a_trap}, {ST_FETCH, 1'b0});
        step(); step(); step();
        check("to_w4", {a_state, a_trap}, {ST_FETCH, 1'b0});
        step();
        check("to_trapped", {a_state, a_trap, 5'(a_en())}, {ST_TRAP, 1'b1, 5'd0});

        // ready on the fourth wait cycle beats the timeout
        opcode = OP_LOAD;
        do_reset();
        step(); step(); step(); mem_ready = 1'b1; #1;
        check("to_late_ready", {a_ir_load, a_pc_load}, 2'b11);
        step();
        check("to_avoid_decode", {a_state, a_trap}, {ST_DECODE, 1'b0});

        // reset mid-access drops mem_re on the next edge
        step(); step(); mem_ready = 1'b0; #1;
        check("mid_rst_before", {a_state, a_mem_re}, {ST_MEM_RD, 1'b1});
        reset = 1'b1;
        step();
        check("mid_rst_after", {a_state, a_mem_re, a_pc_reset}, {ST_RST, 1'b0, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
